// File: rtl/seg7_pkg.sv
// Shared segment type and hex glyph table for the seven-segment scanner.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex 0..F
    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble plus blank to active-low segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       blank,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            seg = HEX_SEG[hex];
        end
    end

endmodule

// File: rtl/seg7_scanner.sv
// Tear-free multiplexed common-anode display driver.
// Define SEG7_BLANKING_EN to darken anodes for BLANK_CYCLES at each slot start.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [4*DIGITS-1:0] wr_data,
    input  logic [DIGITS-1:0]   wr_blank,
    input  logic [DIGITS-1:0]   wr_dp,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg,
    output logic                dp
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int DIV_W = $clog2(REFRESH_DIV);

    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    digit_idx;
    logic                tc;
    logic                fb;
    logic                hs;

    logic                pend_flag;
    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   pend_blank;
    logic [DIGITS-1:0]   pend_dp;

    logic [4*DIGITS-1:0] act_data;
    logic [DIGITS-1:0]   act_blank;
    logic [DIGITS-1:0]   act_dp;

    logic [3:0]          cur_hex;
    logic                cur_blank;
    logic                cur_dp;
    seg_t                cur_seg;
    logic                slot_dark;
    logic [DIGITS-1:0]   an_nxt;

    logic [DIGITS-1:0]   an_q;
    seg_t                seg_q;
    logic                dp_q;

    assign tc = (div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign fb = tc && (digit_idx == IDX_W'(DIGITS - 1));
    assign wr_ready = ~pend_flag;
    assign hs = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else if (tc) begin
            div_cnt   <= '0;
            digit_idx <= fb ? '0 : digit_idx + IDX_W'(1);
        end else begin
            div_cnt   <= div_cnt + DIV_W'(1);
        end
    end

    // Only a write pending before this FB commits; a write taken on
    // the FB itself waits a whole frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_flag  <= 1'b0;
            pend_data  <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
        end else if (hs) begin
            pend_flag  <= 1'b1;
            pend_data  <= wr_data;
            pend_blank <= wr_blank;
            pend_dp    <= wr_dp;
        end else if (fb && pend_flag) begin
            pend_flag  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_data  <= '0;
            act_blank <= '1;
            act_dp    <= '0;
        end else if (fb && pend_flag) begin
            act_data  <= pend_data;
            act_blank <= pend_blank;
            act_dp    <= pend_dp;
        end
    end

    always_comb begin
        cur_hex   = '0;
        cur_blank = 1'b1;
        cur_dp    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_hex   = act_data[4*i +: 4];
                cur_blank = act_blank[i];
                cur_dp    = act_dp[i];
            end
        end
    end

    seg7_decode u_decode (
        .hex   (cur_hex),
        .blank (cur_blank),
        .seg   (cur_seg)
    );

`ifdef SEG7_BLANKING_EN
    assign slot_dark = (div_cnt < DIV_W'(BLANK_CYCLES));
`else
    logic unused_blank_cfg;
    assign slot_dark = 1'b0;
    assign unused_blank_cfg = (BLANK_CYCLES < REFRESH_DIV);
`endif

    assign an_nxt = slot_dark ? '1 : ~(DIGITS'(1) << digit_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_nxt;
            seg_q <= cur_seg;
            dp_q  <= cur_blank | ~cur_dp;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Self-checking bench for seg7_scanner: frame-arithmetic reference model,
// table-driven display vectors and hand-written multi-cycle sequences.
module tb_seg7_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_blank;
    logic [3:0]  wr_dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    seg7_scanner #(
        .DIGITS       (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_blank (wr_blank),
        .wr_dp    (wr_dp),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Cycle k after reset: slot (k/4)%4, frame boundary when k%16 == 15
    function automatic int digit_of(input int k);
        return (k / 4) % 4;
    endfunction

    function automatic logic [3:0] an_of(input int k);
        logic [3:0] v;
        v = 4'b1111;
        v[digit_of(k)] = 1'b0;
`ifdef SEG7_BLANKING_EN
        if ((k % 4) < 1) v = 4'b1111;
`endif
        return v;
    endfunction

    int          m_k;
    logic        m_pend;
    logic [15:0] m_pdata, m_adata;
    logic [3:0]  m_pblank, m_pdp, m_ablank, m_adp;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_k      <= 0;
            m_pend   <= 1'b0;
            m_adata  <= '0;
            m_ablank <= 4'hF;
            m_adp    <= '0;
            m_an     <= 4'hF;
            m_seg    <= 7'h7F;
            m_dp     <= 1'b1;
        end else begin
            m_an  <= an_of(m_k);
            m_seg <= m_ablank[digit_of(m_k)] ? 7'h7F
                     : glyph(m_adata[4*digit_of(m_k) +: 4]);
            m_dp  <= m_ablank[digit_of(m_k)] | ~m_adp[digit_of(m_k)];
            if ((m_k % 16) == 15 && m_pend) begin
                m_adata  <= m_pdata;
                m_ablank <= m_pblank;
                m_adp    <= m_pdp;
                m_pend   <= 1'b0;
            end
            if (wr_valid && !m_pend) begin
                m_pend   <= 1'b1;
                m_pdata  <= wr_data;
                m_pblank <= wr_blank;
                m_pdp    <= wr_dp;
            end
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_an", an, m_an);
            check("model_seg", seg, m_seg);
            check("model_dp", dp, m_dp);
            check("model_ready", wr_ready, !m_pend);
        end
    end

    task automatic wait_ready(input int max, input string name);
        for (int i = 0; i < max && !wr_ready; i++) @(negedge clk);
        if (!wr_ready) timeout(name);
    endtask

    task automatic wait_an(input int d, input int max, input string name);
        logic [3:0] t;
        t = 4'b1111;
        t[d] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < max && an !== t; i++) @(negedge clk);
        if (an !== t) timeout(name);
    endtask

    task automatic write_word(input logic [15:0] d, input logic [3:0] b,
                              input logic [3:0] p);
        wait_ready(40, "write_ready");
        wr_valid = 1'b1;
        wr_data  = d;
        wr_blank = b;
        wr_dp    = p;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  blank;
        logic [3:0]  dpv;
        logic [6:0]  seg [4];
        logic [3:0]  dpo;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0].data = 16'h1A80; vecs[0].blank = 4'b0000; vecs[0].dpv = 4'b0010;
        vecs[0].seg = '{7'h40, 7'h00, 7'h08, 7'h79}; vecs[0].dpo = 4'b1101;
        vecs[1].data = 16'hFFFF; vecs[1].blank = 4'b1000; vecs[1].dpv = 4'b1000;
        vecs[1].seg = '{7'h0E, 7'h0E, 7'h0E, 7'h7F}; vecs[1].dpo = 4'b1111;
        vecs[2].data = 16'h3C5E; vecs[2].blank = 4'b0001; vecs[2].dpv = 4'b1111;
        vecs[2].seg = '{7'h7F, 7'h12, 7'h46, 7'h30}; vecs[2].dpo = 4'b0001;
        vecs[3].data = 16'h79B6; vecs[3].blank = 4'b0000; vecs[3].dpv = 4'b0101;
        vecs[3].seg = '{7'h02, 7'h03, 7'h10, 7'h78}; vecs[3].dpo = 4'b1010;

        rst_n = 1'b0; wr_valid = 1'b0;
        wr_data = '0; wr_blank = '0; wr_dp = '0;
        @(posedge clk);
        chk_en = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_ready", wr_ready, 1'b1);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("dark_seg", seg, 7'h7F);
            check("dark_dp", dp, 1'b1);
        end

        for (int i = 0; i < 4; i++) begin
            write_word(vecs[i].data, vecs[i].blank, vecs[i].dpv);
            wait_ready(40, "vec_commit");
            for (int d = 0; d < 4; d++) begin
                wait_an(d, 20, "vec_an");
                check($sformatf("vec%0d_seg%0d", i, d), seg, vecs[i].seg[d]);
                check($sformatf("vec%0d_dp%0d", i, d), dp, vecs[i].dpo[d]);
            end
        end

        wait_ready(40, "b2b_pre");
        wr_valid = 1'b1; wr_data = 16'h1111; wr_blank = '0; wr_dp = '0;
        @(negedge clk);
        check("b2b_busy", wr_ready, 1'b0);
        wr_data = 16'h2222;
        wait_ready(40, "b2b_commit1");
        @(negedge clk);
        wr_valid = 1'b0;
        check("b2b_busy2", wr_ready, 1'b0);
        check("b2b_first", seg, 7'h79);
        wait_ready(40, "b2b_commit2");
        for (int d = 0; d < 4; d++) begin
            wait_an(d, 20, "b2b_an");
            check("b2b_second", seg, 7'h24);
        end

        wait_ready(40, "fb_pre");
        for (int i = 0; i < 20 && (m_k % 16) != 15; i++) @(negedge clk);
        wr_valid = 1'b1; wr_data = 16'h4444; wr_blank = '0; wr_dp = '0;
        @(negedge clk);
        wr_valid = 1'b0;
        cnt = 0;
        while (!wr_ready && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("fb_wait", 16'(cnt), 16'd16);
        wait_an(0, 20, "fb_an");
        check("fb_seg", seg, 7'h19);

        write_word(16'h5555, 4'h0, 4'h0);
        check("rstp_pend", wr_ready, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rstp_an", an, 4'hF);
        check("rstp_seg", seg, 7'h7F);
        check("rstp_dp", dp, 1'b1);
        check("rstp_ready", wr_ready, 1'b1);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            check("rstp_dark", seg, 7'h7F);
        end

        for (int i = 0; i < 300; i++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_data  = 16'($urandom);
            wr_blank = 4'($urandom);
            wr_dp    = 4'($urandom);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scanner.md
# seg7_scanner

Output-side display driver: takes hex values written by the processor and time-multiplexes them onto the board's common-anode seven-segment display. It is the outbound counterpart of the button-conditioning path. Buttons are filtered on the way in; display digits are scanned, refreshed and written tear-free on the way out. The block sits between the memory-mapped I/O write port and the display pins.

## Interface
- `DIGITS`, default 4: number of multiplexed digits (2..8).
- `REFRESH_DIV`, default 50000: clock cycles per digit slot (≥ 4).
- `BLANK_CYCLES`, default 500: anode-off cycles at the start of each slot; must be < `REFRESH_DIV`.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `wr_valid`, in, 1: write request.
- `wr_ready`, out, 1: block can accept a write.
- `wr_data`, in, 4*DIGITS: hex nibbles; nibble 0 drives the rightmost digit (anode 0).
- `wr_blank`, in, DIGITS: per-digit blank; 1 forces all segments off.
- `wr_dp`, in, DIGITS: per-digit decimal point; 1 lights it.
- `an`, out, DIGITS: anode enables, active-low.
- `seg`, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`, out, 1: decimal point, active-low.

## Operation
- **Divider.** `div_cnt` counts 0..REFRESH_DIV-1, then wraps to 0. The terminal count (TC) advances `digit_idx`.
- **Digit index.** `digit_idx` counts 0..DIGITS-1 and wraps to 0. A wrap from DIGITS-1 to 0 on TC is a frame boundary (FB).
- **Active register.** Holds data, blank and dp. The scan reads only this register.
- **Pending register.** A write handshake happens when `wr_valid && wr_ready`.
  - It captures `wr_data`, `wr_blank` and `wr_dp` into the pending register.
  - It sets `pend_flag`, so `wr_ready` = 0 from the next cycle.
- **Commit.** On an FB cycle with `pend_flag` already set (set in an earlier cycle), the pending register copies to active and `pend_flag` clears. `wr_ready` = 1 the following cycle.
- **Write on an FB cycle.** A write accepted in an FB cycle is not committed at that FB. It commits at the next FB.
- **wr_valid while not ready.** Ignored; no data is captured.
- **Decoding.**
  - Hex 0..F maps to standard glyphs: 0 = 7'h40, 1 = 7'h79, 8 = 7'h00, A = 7'h08, F = 7'h0E.
  - A blanked digit gives `seg` = 7'h7F and `dp` = 1, regardless of `wr_dp`.
- **Anode.** `an` = ~(1 << digit_idx). This bit pattern is modified by blanking (see Configuration).

## Timing
- **Reset values** (next edge with `rst_n` = 0):
  - `an` = all 1s, `seg` = 7'h7F, `dp` = 1, `wr_ready` = 1.
  - `div_cnt` = 0, `digit_idx` = 0, `pend_flag` = 0.
  - Active register: data = 0, blank = all 1s, dp = 0.
- **Reset mid-operation.** Reset during a pending write discards the pending write; behaviour is then exactly the reset state.
- **Registered outputs.** `an`, `seg` and `dp` change one cycle after `digit_idx` or the active register changes.
- **Write latency.** From handshake to the new value visible on a digit: at most (DIGITS·REFRESH_DIV + 2) cycles.
- **Throughput.** At most one accepted write per frame.
- **First slot after reset.** The first digit slot begins the cycle after reset deasserts; `div_cnt` = 0 in that cycle.

## Configuration
- **`SEG7_BLANKING_EN` defined:**
  - While `div_cnt` < BLANK_CYCLES, `an` = all 1s. This suppresses ghosting between digits.
  - `seg` and `dp` still update at slot start.
- **`SEG7_BLANKING_EN` undefined:**
  - The anode is active for the whole slot.
  - `BLANK_CYCLES` is ignored and its comparator is not built.

## Structure
- **Package `seg7_pkg`:**
  - `SEG_OFF` = 7'h7F.
  - 16-entry hex-to-segment constant table.
  - Typedef `seg_t` (logic [6:0]).
- **Sub-module `seg7_decode`:** combinational 4-bit hex plus blank to `seg_t`, using the package table. It is instantiated once, on the muxed nibble.

## Test plan
Benches use `REFRESH_DIV` = 4, `BLANK_CYCLES` = 1, `DIGITS` = 4.
1. Reset with `rst_n` = 0 for 3 cycles → `an` = 4'hF, `seg` = 7'h7F, `dp` = 1, `wr_ready` = 1. After release, all digits remain dark (blank = 1111).
2. Write `wr_data` = 16'h1A80, `wr_blank` = 0, `wr_dp` = 4'b0010 → after the next FB, the following `an`/`seg` pairs are seen, with `dp` = 0 only on digit 1:

   | `an` | `seg` | Digit |
   |---|---|---|
   | 1110 | 7'h40 | 0 |
   | 1101 | 7'h00 | 8 |
   | 1011 | 7'h08 | A |
   | 0111 | 7'h79 | 1 |

3. Two back-to-back writes (16'h1111 then 16'h2222) → only the first is accepted; `wr_ready` stays 0 until one cycle after the FB commit. The second must be re-presented and then displays 2222.
4. Write accepted exactly on an FB cycle → the display is unchanged that frame and shows the new value after the following FB.
5. `wr_blank` = 4'b1000 with data 16'hFFFF → digit 3 shows `seg` = 7'h7F and `dp` = 1; digits 0..2 show 7'h0E.
6. With `SEG7_BLANKING_EN`, `an` = 4'hF during `div_cnt` = 0 of every slot. Without it, exactly one `an` bit is low in every cycle after the first commit. Assert `rst_n` = 0 while `pend_flag` = 1 → the reset state returns and the pending write never appears.
